// File: rtl/noc_pkg.sv
// Shared NoC switch definitions: flit format and port indexing.
package noc_pkg;

    localparam int unsigned DATA_WIDTH     = 37;
    localparam int unsigned N_PORTS        = 4;
    localparam int unsigned OBUF_DEPTH_DEF = 3;
    localparam int unsigned CNT_WIDTH_DEF  = 16;

    typedef logic [DATA_WIDTH-1:0]       flit_t;
    typedef logic [$clog2(N_PORTS)-1:0]  port_idx_t;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// rr_ptr, wrapping around to index 0.
module noc_rr_arbiter
    import noc_pkg::*;
#(
    parameter int unsigned N_IN = N_PORTS
) (
    input  logic [N_IN-1:0]         req,
    input  logic [$clog2(N_IN)-1:0] rr_ptr,
    output logic [N_IN-1:0]         gnt,
    output logic [$clog2(N_IN)-1:0] gnt_idx,
    output logic                    any_gnt
);

    localparam int unsigned IW = $clog2(N_IN);

    // Two passes: upper segment [rr_ptr, N_IN) first, then the wrapped part.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (!any_gnt && req[i] && (i >= 32'(rr_ptr))) begin
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
                any_gnt = 1'b1;
            end
        end
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (!any_gnt && req[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
                any_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_out_arbiter.sv
// Output-port stage of the NoC switch: round-robin reads from the per-input
// queues, captures the returned flits into a small FIFO buffer and presents
// them on a valid/ready link, counting delivered flits.
module noc_out_arbiter #(
    parameter int unsigned N_IN       = noc_pkg::N_PORTS,
    parameter int unsigned DATA_WIDTH = noc_pkg::DATA_WIDTH,
    parameter int unsigned OBUF_DEPTH = noc_pkg::OBUF_DEPTH_DEF,
    parameter int unsigned CNT_WIDTH  = noc_pkg::CNT_WIDTH_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_IN-1:0]              fifo_empty,
    input  logic [N_IN*DATA_WIDTH-1:0]   fifo_data,
    output logic [N_IN-1:0]              fifo_rd_en,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [$clog2(N_IN)-1:0]      out_src,
    input  logic                         out_ready,
    output logic [CNT_WIDTH-1:0]         flit_cnt
);

    localparam int unsigned IW = $clog2(N_IN);
    localparam int unsigned PW = $clog2(OBUF_DEPTH);
    localparam int unsigned OW = $clog2(OBUF_DEPTH + 1);

    logic [IW-1:0]         rr_ptr;
    logic [IW-1:0]         gnt_idx;
    logic [IW-1:0]         inflight_src;
    logic                  inflight;
    logic [N_IN-1:0]       req;
    logic [N_IN-1:0]       gnt;
    logic                  any_gnt;
    logic                  has_credit;
    logic                  issue;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] ret_data;
    logic [DATA_WIDTH-1:0] buf_data [OBUF_DEPTH];
    logic [IW-1:0]         buf_src  [OBUF_DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [OW-1:0]         occ;
    logic [CNT_WIDTH-1:0]  cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req = ~fifo_empty;

    noc_rr_arbiter #(.N_IN(N_IN)) u_rr (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any_gnt (any_gnt)
    );

    // Credit uses registered occupancy only, so out_ready never reaches rd_en;
    // a read is only issued if buffer + in-flight + this read still fit.
    assign has_credit = (32'(occ) + 32'(inflight)) < OBUF_DEPTH;
    assign issue      = has_credit & any_gnt & ~rst;
    assign fifo_rd_en = issue ? gnt : '0;

    assign ret_data = fifo_data[32'(inflight_src)*DATA_WIDTH +: DATA_WIDTH];
    assign push     = inflight;
    assign pop      = (occ != '0) & out_ready;

    assign out_valid = (occ != '0);
    assign out_data  = buf_data[head];
    assign out_src   = buf_src[head];
    assign flit_cnt  = cnt;

    // Round-robin pointer and the one-cycle FIFO read tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            inflight     <= 1'b0;
            inflight_src <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_src <= gnt_idx;
                rr_ptr       <= (gnt_idx == IW'(N_IN - 1)) ? '0 : gnt_idx + IW'(1);
            end
        end
    end

    // Circular output buffer: push returned flits, pop on link handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < OBUF_DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_src[i]  <= '0;
            end
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                buf_data[tail] <= ret_data;
                buf_src[tail]  <= inflight_src;
                tail           <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (push && !pop) begin
                occ <= occ + OW'(1);
            end else if (pop && !push) begin
                occ <= occ - OW'(1);
            end
        end
    end

    // Delivered-flit counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (pop) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Directed self-checking bench for noc_out_arbiter with a queue scoreboard
// and a behavioural model of the upstream queues (1-cycle read latency).
module tb_noc_out_arbiter;

    localparam int NI = 4;
    localparam int DW = 37;
    localparam int CW = 4;

    typedef struct packed {
        logic [1:0]    src;
        logic [DW-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NI-1:0]     fifo_empty;
    logic [NI*DW-1:0]  fifo_data;
    logic [NI-1:0]     fifo_rd_en;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [1:0]        out_src;
    logic              out_ready;
    logic [CW-1:0]     flit_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q [NI][$];
    exp_t          sb[$];
    int            glog[$];
    logic [CW-1:0] model_cnt;
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic [1:0]    prev_src;
    logic [NI-1:0] s_rd_en;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic [1:0]    s_src;

    noc_out_arbiter #(
        .N_IN       (NI),
        .DATA_WIDTH (DW),
        .OBUF_DEPTH (3),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_ready  (out_ready),
        .flit_cnt   (flit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_empty();
        for (int i = 0; i < NI; i++) fifo_empty[i] = (q[i].size() == 0);
    endtask

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) q[i].push_back({5'(k), 32'($urandom)});
        update_empty();
    endtask

    // One clock cycle: observe at negedge, then model the queues after posedge.
    task automatic tick();
        int g;
        g = -1;
        @(negedge clk);
        s_rd_en = fifo_rd_en;
        s_valid = out_valid;
        s_data  = out_data;
        s_src   = out_src;
        check("flit_cnt", 64'(flit_cnt), 64'(model_cnt));
        if (prev_stall) begin
            check("hold_data", 64'(out_data), 64'(prev_data));
            check("hold_src", 64'(out_src), 64'(prev_src));
        end
        if (fifo_rd_en != '0) begin
            check("rd_en_onehot", 64'($onehot(fifo_rd_en)), 64'd1);
            for (int i = 0; i < NI; i++) if (fifo_rd_en[i]) g = i;
            check("grant_nonempty", 64'(q[g].size() != 0), 64'd1);
            if (q[g].size() != 0) sb.push_back({2'(g), q[g][0]});
            glog.push_back(g);
        end
        check("readahead_bound", 64'(sb.size() <= 3), 64'd1);
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_pop", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_src", 64'(out_src), 64'(e.src));
            end
            model_cnt = model_cnt + 1'b1;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_src   = out_src;
        @(posedge clk);
        #1;
        if (g >= 0 && q[g].size() != 0) fifo_data[g*DW +: DW] = q[g].pop_front();
        update_empty();
    endtask

    task automatic clear_model();
        for (int i = 0; i < NI; i++) q[i].delete();
        sb.delete();
        glog.delete();
        fifo_data  = '0;
        model_cnt  = '0;
        prev_stall = 1'b0;
        update_empty();
    endtask

    task automatic drain(input int max_cycles);
        logic done;
        done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            if (sb.size() == 0 && fifo_empty == '1) done = 1'b1;
            else tick();
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        out_ready = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_src", 64'(out_src), 64'd0);
        check("rst_cnt", 64'(flit_cnt), 64'd0);
        rst = 1'b0;

        // Streaming: all queues loaded, grants rotate 0,1,2,3.
        out_ready = 1'b1;
        for (int i = 0; i < NI; i++) load(i, 6);
        glog.delete();
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c >= 3) check("stream_valid", 64'(s_valid), 64'd1);
        end
        check("stream_glog_size", 64'(glog.size() >= 8), 64'd1);
        for (int k = 0; k < 8 && k < glog.size(); k++)
            check("stream_grant", 64'(glog[k]), 64'(k % 4));

        // Mid-stream reset: outputs forced at once, nothing stale afterwards.
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_data", 64'(out_data), 64'd0);
        check("mid_rst_src", 64'(out_src), 64'd0);
        check("mid_rst_cnt", 64'(flit_cnt), 64'd0);
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_valid", 64'(s_valid), 64'd0);
        end

        // Single request from input 2: grant cycle 1, valid at cycle 3.
        q[2].push_back(37'h0_1234_5678);
        update_empty();
        tick();
        check("single_rd_en", 64'(s_rd_en), 64'b0100);
        tick();
        check("single_valid_c2", 64'(s_valid), 64'd0);
        tick();
        check("single_valid_c3", 64'(s_valid), 64'd1);
        check("single_data", 64'(s_data), 64'h0_1234_5678);
        check("single_src", 64'(s_src), 64'd2);
        tick();
        check("single_cnt", 64'(flit_cnt), 64'd1);

        // Backpressure: only three reads ahead, head held stable, then drain in order.
        out_ready = 1'b0;
        for (int i = 0; i < NI; i++) load(i, 4);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (s_rd_en != '0) n++;
        end
        check("bp_pulses", 64'(n), 64'd3);
        check("bp_valid", 64'(s_valid), 64'd1);
        out_ready = 1'b1;
        drain(60);

        // Fairness: after a grant to 3, inputs 0 and 3 alternate.
        load(3, 1);
        glog.delete();
        tick();
        check("fair_first", 64'(s_rd_en), 64'b1000);
        load(0, 4);
        load(3, 4);
        glog.delete();
        drain(40);
        check("fair_glog_size", 64'(glog.size()), 64'd8);
        for (int k = 0; k < 8 && k < glog.size(); k++)
            check("fair_grant", 64'(glog[k]), 64'((k % 2 == 0) ? 0 : 3));

        // Counter wrap: 17 deliveries on a 4-bit counter leaves 1.
        do_reset();
        load(1, 17);
        drain(80);
        tick();
        check("cnt_wrap", 64'(flit_cnt), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
